mem_region_router: RTL

- Parametrised successor to the processor's data-memory address decoder.
- Routes one CPU load/store port to one general 32-bit bank, NUM_IMG_BANKS 8-bit image banks and an internal MMIO block (LEDs, buttons).
- Aligns read-data muxing to the banks' registered read latency and adds byte enables, read-valid, decode-error reporting and synchronised button edge capture.
- Sits between the CPU data port and the external synchronous RAM instances.

---
 rtl/mem_region_pkg.sv | 37 +++
 rtl/btn_sync_edge.sv | 34 +++
 rtl/mem_region_router.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_region_pkg.sv
// Shared types for the data-memory region router: region classes, MMIO word map
// and the read token carried through the load-latency pipeline.
package mem_region_pkg;

  typedef enum logic [1:0] {
    REG_GEN      = 2'd0,
    REG_IMG_BASE = 2'd1,
    REG_MMIO     = 2'd2,
    REG_UNMAPPED = 2'd3
  } region_e;

  localparam logic [1:0] MMIO_LED  = 2'd0;
  localparam logic [1:0] MMIO_BTN  = 2'd1;
  localparam logic [1:0] MMIO_EDGE = 2'd2;
  localparam logic [1:0] MMIO_ID   = 2'd3;

  localparam int TOKEN_SEL_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [TOKEN_SEL_W-1:0] sel;
    logic [31:0]            mmio_rdata;
    logic                   unmapped;
  } rd_token_t;

  // Region 0 is the general bank, the next num_img selects are image banks and the
  // all-ones select is MMIO; anything left over between them is unmapped.
  function automatic region_e region_of(input int unsigned sel,
                                        input int unsigned num_img,
                                        input int unsigned sel_w);
    if (sel == 0) return REG_GEN;
    if (sel <= num_img) return REG_IMG_BASE;
    if (sel == (32'd1 << sel_w) - 32'd1) return REG_MMIO;
    return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for asynchronous button levels, followed by a delay flop
// so that a rising edge of the synchronised level produces a one-cycle pulse.
module btn_sync_edge
  import mem_region_pkg::*;
#(
  parameter int NUM_BTN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] buttons,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] rise
);

  logic [NUM_BTN-1:0] meta;
  logic [NUM_BTN-1:0] sync;
  logic [NUM_BTN-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= buttons;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;

endmodule

// File: rtl/mem_region_router.sv
// Data-memory region router: decodes the CPU load/store port onto a general bank,
// a row of 8-bit image banks and a small MMIO block, and realigns read data to the
// banks' registered latency.
module mem_region_router
  import mem_region_pkg::*;
#(
  parameter int NUM_IMG_BANKS = 6,
  parameter int SEL_W         = 3,
  parameter int SEL_LSB       = 16,
  parameter int GEN_ADDR_W    = 12,
  parameter int IMG_ADDR_W    = 16,
  parameter int RD_LAT        = 1,
  parameter int NUM_BTN       = 4
) (
  input  logic                       CLK,
  input  logic                       RST_n,
  input  logic                       req_i,
  input  logic                       wren_i,
  input  logic [31:0]                address_i,
  input  logic [31:0]                data_i,
  input  logic [3:0]                 be_i,
  output logic [31:0]                data_o,
  output logic                       rvalid_o,
  output logic                       err_o,
  output logic [GEN_ADDR_W-1:0]      gen_addr_o,
  output logic [31:0]                gen_data_o,
  output logic [3:0]                 gen_be_o,
  output logic                       gen_wren_o,
  input  logic [31:0]                gen_q_i,
  output logic [IMG_ADDR_W-1:0]      img_addr_o,
  output logic [7:0]                 img_data_o,
  output logic [NUM_IMG_BANKS-1:0]   img_wren_o,
  input  logic [8*NUM_IMG_BANKS-1:0] img_q_i,
  input  logic [NUM_BTN-1:0]         buttons_i,
  output logic [7:0]                 LEDs_o
);

  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   img_idx;
  logic [1:0]         mmio_word;
  region_e            region;
  logic               mmio_we;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] edge_cap;
  logic [NUM_BTN-1:0] edge_clr;
  logic [7:0]         leds;
  logic [31:0]        mmio_rdata;
  logic               err_q;
  logic               unused_addr;

  assign sel         = address_i[SEL_LSB +: SEL_W];
  assign img_idx     = sel - SEL_W'(1);
  assign mmio_word   = address_i[3:2];
  assign region      = region_of(32'(sel), NUM_IMG_BANKS, SEL_W);
  assign unused_addr = ^address_i;

  assign gen_addr_o = address_i[GEN_ADDR_W-1:0];
  assign gen_data_o = data_i;
  assign gen_be_o   = be_i;
  assign img_addr_o = address_i[IMG_ADDR_W-1:0];
  assign img_data_o = data_i[7:0];

  always_comb begin
    gen_wren_o = 1'b0;
    img_wren_o = '0;
    mmio_we    = 1'b0;
    if (req_i && wren_i) begin
      case (region)
        REG_GEN:      gen_wren_o = 1'b1;
        REG_IMG_BASE: if (be_i[0]) img_wren_o = NUM_IMG_BANKS'(1) << img_idx;
        REG_MMIO:     mmio_we = 1'b1;
        default:      ;
      endcase
    end
  end

  btn_sync_edge #(
    .NUM_BTN (NUM_BTN)
  ) u_btn (
    .clk     (CLK),
    .rst_n   (RST_n),
    .buttons (buttons_i),
    .level   (btn_level),
    .rise    (btn_rise)
  );

  assign edge_clr = (mmio_we && mmio_word == MMIO_EDGE) ? data_i[NUM_BTN-1:0] : '0;

  // A fresh edge wins over a simultaneous write-one-to-clear so no press is lost.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      leds     <= '0;
      edge_cap <= '0;
    end else begin
      if (mmio_we && mmio_word == MMIO_LED && be_i[0]) leds <= data_i[7:0];
      edge_cap <= (edge_cap & ~edge_clr) | btn_rise;
    end
  end

  assign LEDs_o = leds;

  always_comb begin
    mmio_rdata = '0;
    case (mmio_word)
      MMIO_LED:  mmio_rdata = {24'h0, leds};
      MMIO_BTN:  mmio_rdata = 32'(btn_level);
      MMIO_EDGE: mmio_rdata = 32'(edge_cap);
      default:   mmio_rdata = {16'h0, 8'(SEL_W), 8'(NUM_IMG_BANKS)};
    endcase
  end

  rd_token_t launch;
  rd_token_t pipe [RD_LAT];
  rd_token_t tail;

  always_comb begin
    launch            = '0;
    launch.valid      = req_i && !wren_i;
    launch.sel        = TOKEN_SEL_W'(sel);
    launch.unmapped   = (region == REG_UNMAPPED);
    launch.mmio_rdata = (region == REG_MMIO) ? mmio_rdata : '0;
  end

  // Token delay matches the banks' registered read latency, so gen_q_i/img_q_i are
  // live exactly when the matching token reaches the tail.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= launch;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[RD_LAT-1];

  region_e                tail_region;
  logic [TOKEN_SEL_W-1:0] tail_idx;

  assign tail_region = region_of(32'(tail.sel), NUM_IMG_BANKS, SEL_W);
  assign tail_idx    = tail.sel - TOKEN_SEL_W'(1);

  always_comb begin
    rvalid_o = tail.valid;
    data_o   = '0;
    if (tail.valid && !tail.unmapped) begin
      case (tail_region)
        REG_GEN: data_o = gen_q_i;
        REG_IMG_BASE: begin
          for (int k = 0; k < NUM_IMG_BANKS; k++) begin
            if (tail_idx == TOKEN_SEL_W'(k)) data_o = {24'h0, img_q_i[8*k +: 8]};
          end
        end
        REG_MMIO: data_o = tail.mmio_rdata;
        default:  data_o = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) err_q <= 1'b0;
    else        err_q <= req_i && (region == REG_UNMAPPED);
  end

  assign err_o = err_q;

endmodule
